// File: rtl/midi_pkg.sv
// Shared constants, FSM state type and the status-byte length decoder
// for the MIDI transmit path.
package midi_pkg;
  localparam int MIDI_CLK_DIV = 800;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PBEND    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;

  localparam logic [7:0] RT_MIN    = 8'hF8;
  localparam logic [7:0] SYSEX_END = 8'hF7;

  typedef enum logic [2:0] {IDLE, SEND_STATUS, SEND_D1, SEND_D2, SEND_RT} tx_state_t;

  // Number of data bytes that follow a status byte.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    data_len = 2'd0;
    case (status[7:4])
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PBEND: data_len = 2'd2;
      PROG, CH_AT:                           data_len = 2'd1;
      SYS: begin
        case (status[3:0])
          4'h1, 4'h3: data_len = 2'd1;
          4'h2:       data_len = 2'd2;
          default:    data_len = 2'd0;
        endcase
      end
      default: data_len = 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/midi_msg_tx_if.sv
// Message / real-time request bus between the synth control logic and the
// MIDI transmitter, plus the transmitter's status outputs.
interface midi_msg_tx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic       rt_ready;
  logic       running_status_en;
  logic       midi_txd;
  logic       busy;
  logic       msg_err;

  modport master (
    output msg_valid, msg_status, msg_data1, msg_data2, rt_valid, rt_byte,
           running_status_en,
    input  msg_ready, rt_ready, midi_txd, busy, msg_err
  );

  modport slave (
    input  msg_valid, msg_status, msg_data1, msg_data2, rt_valid, rt_byte,
           running_status_en,
    output msg_ready, rt_ready, midi_txd, busy, msg_err
  );
endinterface

// File: rtl/midi_tx_byte.sv
// 8N1 byte serializer: bit-period divider plus 10-bit frame shifter.
// byte_ready is also high in the last stop-bit cycle so frames chain gaplessly.
module midi_tx_byte #(
  parameter int CLK_DIV = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       txd,
  output logic       active
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          bit_end, last_cycle;

  assign bit_end    = div_cnt == DW'(CLK_DIV - 1);
  assign last_cycle = active && bit_cnt == 4'd9 && bit_end;
  assign byte_ready = !active || last_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
      txd     <= 1'b1;
    end else begin
      // Output is a registered copy of the frame head, one cycle behind the load.
      txd <= active ? shreg[0] : 1'b1;
      if (byte_valid && byte_ready) begin
        active  <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        shreg   <= {1'b1, byte_data, 1'b0};
      end else if (active) begin
        if (bit_end) begin
          div_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            shreg   <= {1'b1, shreg[9:1]};
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/midi_msg_tx.sv
// MIDI OUT message transmitter: byte-count decode, running-status compression
// and real-time byte insertion in front of the 8N1 serializer.
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int CLK_DIV       = MIDI_CLK_DIV,
  parameter bit RS_EN_DEFAULT = 1'b1
) (
  input logic          CLOCK_25,
  input logic          reset_reg_N,
  midi_msg_tx_if.slave bus
);
  tx_state_t  state, state_nxt, ret_q, ret_nxt, first_st, after_field;
  logic [7:0] status_q, rt_q, last_status, field, byte_data;
  logic [6:0] d1_q, d2_q;
  logic [1:0] len_q;
  logic       rt_pend, err_q, byte_valid, byte_ready, ser_active, rt_sent, txd;
  logic       msg_acc, rt_acc, is_chan, is_sys_common, skip;
  logic       unused;

  assign unused = &{1'b0, RS_EN_DEFAULT, bus.msg_data1[7], bus.msg_data2[7]};

  assign msg_acc       = bus.msg_valid && state == IDLE;
  assign rt_acc        = bus.rt_valid && !rt_pend;
  assign is_chan       = bus.msg_status[7] && bus.msg_status[7:4] != SYS;
  assign is_sys_common = bus.msg_status[7:4] == SYS && bus.msg_status < RT_MIN;
  assign skip          = bus.running_status_en && is_chan && bus.msg_status == last_status;
  assign first_st      = skip ? SEND_D1 : SEND_STATUS;

  always_comb begin
    field       = status_q;
    after_field = IDLE;
    case (state)
      SEND_STATUS: after_field = (len_q == 2'd0) ? IDLE : SEND_D1;
      SEND_D1: begin
        field       = {1'b0, d1_q};
        after_field = (len_q == 2'd2) ? SEND_D2 : IDLE;
      end
      SEND_D2: field = {1'b0, d2_q};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_q;
    byte_valid = 1'b0;
    byte_data  = rt_q;
    rt_sent    = 1'b0;
    case (state)
      IDLE: begin
        if (msg_acc && bus.msg_status[7]) begin
          if (rt_pend || rt_acc) begin
            state_nxt = SEND_RT;
            ret_nxt   = first_st;
          end else begin
            state_nxt = first_st;
          end
        end else if (rt_pend) begin
          state_nxt = SEND_RT;
          ret_nxt   = IDLE;
        end
      end
      SEND_RT: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          rt_sent   = 1'b1;
          state_nxt = ret_q;
        end
      end
      default: begin
        byte_valid = 1'b1;
        // A pending rt byte takes the next boundary; park in SEND_RT until then.
        if (rt_pend) begin
          if (byte_ready) begin
            rt_sent = 1'b1;
          end else begin
            state_nxt = SEND_RT;
            ret_nxt   = state;
          end
        end else begin
          byte_data = field;
          if (byte_ready) state_nxt = after_field;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (!reset_reg_N) begin
      state       <= IDLE;
      ret_q       <= IDLE;
      status_q    <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      len_q       <= '0;
      rt_pend     <= 1'b0;
      rt_q        <= '0;
      last_status <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      ret_q <= ret_nxt;
      err_q <= msg_acc && !bus.msg_status[7];
      if (msg_acc) begin
        status_q <= bus.msg_status;
        d1_q     <= bus.msg_data1[6:0];
        d2_q     <= bus.msg_data2[6:0];
        len_q    <= data_len(bus.msg_status);
      end
      if (rt_acc) begin
        rt_pend <= 1'b1;
        rt_q    <= bus.rt_byte;
      end else if (rt_sent) begin
        rt_pend <= 1'b0;
      end
      if (!bus.running_status_en)
        last_status <= '0;
      else if (msg_acc && is_chan)
        last_status <= bus.msg_status;
      else if (msg_acc && is_sys_common)
        last_status <= '0;
    end
  end

  midi_tx_byte #(.CLK_DIV(CLK_DIV)) u_ser (
    .clk       (CLOCK_25),
    .rst_n     (reset_reg_N),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .txd       (txd),
    .active    (ser_active)
  );

  assign bus.midi_txd  = txd;
  assign bus.msg_ready = state == IDLE;
  assign bus.rt_ready  = !rt_pend;
  assign bus.busy      = state != IDLE || ser_active || rt_pend;
  assign bus.msg_err   = err_q;
endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed bench for midi_msg_tx: a UART-style monitor decodes midi_txd and
// each message is compared against hand-computed byte sequences and timing.
module tb_midi_msg_tx;
  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_msg_tx_if bus();

  midi_msg_tx #(.CLK_DIV(DIV), .RS_EN_DEFAULT(1'b1)) dut (
    .CLOCK_25   (clk),
    .reset_reg_N(rst_n),
    .bus        (bus)
  );

  // Decoded frames
  logic [7:0] q_byte[$];
  int         q_start[$];
  logic       q_ok[$];
  int         mon_s;
  logic [7:0] mon_b;
  logic       mon_ok;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.midi_txd === 1'b0) begin
        mon_s = cyc;
        mon_ok = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        if (bus.midi_txd !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_b[i] = bus.midi_txd;
        end
        repeat (DIV) @(negedge clk);
        if (bus.midi_txd !== 1'b1) mon_ok = 1'b0;
        q_byte.push_back(mon_b);
        q_start.push_back(mon_s);
        q_ok.push_back(mon_ok);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_msg(input logic [7:0] st, d1, d2, input logic en,
                           input logic with_rt, input logic [7:0] rtb, output int acc);
    @(negedge clk);
    chk("ready_before_send", bus.msg_ready, 1'b1);
    q_byte.delete(); q_start.delete(); q_ok.delete();
    bus.running_status_en = en;
    bus.msg_status = st;
    bus.msg_data1 = d1;
    bus.msg_data2 = d2;
    bus.msg_valid = 1'b1;
    if (with_rt) begin
      bus.rt_valid = 1'b1;
      bus.rt_byte = rtb;
    end
    @(posedge clk); #1;
    acc = cyc;
    bus.msg_valid = 1'b0;
    bus.rt_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int rdy);
    rdy = -1;
    for (int k = 0; k < 80 * DIV; k++) begin
      @(negedge clk);
      if (bus.msg_ready && rdy < 0) rdy = cyc;
      if (bus.msg_ready && !bus.busy) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s done_timeout: still busy after %0d cycles", tag, 80 * DIV);
  endtask

  task automatic check_frames(input string tag, input int n, input logic [31:0] ex, input int acc);
    chk({tag, " count"}, q_byte.size(), n);
    for (int i = 0; i < n && i < q_byte.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), q_byte[i], ex[8*i +: 8]);
      chk($sformatf("%s stop%0d", tag, i), q_ok[i], 1'b1);
      if (i == 0) chk({tag, " first_start"}, q_start[0], acc + 2);
      else chk($sformatf("%s gap%0d", tag, i), q_start[i] - q_start[i-1], FRAME);
    end
  endtask

  typedef struct {
    logic [7:0]  st, d1, d2;
    logic        en;
    int          n;
    logic [31:0] ex;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int acc, rdy;
    vecs[0]  = '{8'h90, 8'h3C, 8'h64, 1'b1, 3, 32'h00643C90};
    vecs[1]  = '{8'h90, 8'h3E, 8'h40, 1'b1, 2, 32'h0000403E};
    vecs[2]  = '{8'h90, 8'h3E, 8'h40, 1'b0, 3, 32'h00403E90};
    vecs[3]  = '{8'hB0, 8'h07, 8'h7F, 1'b1, 3, 32'h007F07B0};
    vecs[4]  = '{8'hF2, 8'h10, 8'h20, 1'b1, 3, 32'h002010F2};
    vecs[5]  = '{8'hB0, 8'h07, 8'h00, 1'b1, 3, 32'h000007B0};
    vecs[6]  = '{8'hB0, 8'h07, 8'h01, 1'b1, 2, 32'h00000107};
    vecs[7]  = '{8'hC5, 8'h85, 8'h00, 1'b1, 2, 32'h000005C5};
    vecs[8]  = '{8'hC5, 8'h10, 8'h00, 1'b1, 1, 32'h00000010};
    vecs[9]  = '{8'hF8, 8'h00, 8'h00, 1'b1, 1, 32'h000000F8};
    vecs[10] = '{8'hC5, 8'h20, 8'h00, 1'b1, 1, 32'h00000020};
    vecs[11] = '{8'hF6, 8'h00, 8'h00, 1'b1, 1, 32'h000000F6};
    vecs[12] = '{8'hC5, 8'h30, 8'h00, 1'b1, 2, 32'h000030C5};
    vecs[13] = '{8'hE0, 8'h80, 8'h40, 1'b1, 3, 32'h004000E0};
    vecs[14] = '{8'hF1, 8'h55, 8'h00, 1'b1, 2, 32'h000055F1};
    vecs[15] = '{8'hD3, 8'h7F, 8'h00, 1'b1, 2, 32'h00007FD3};

    bus.msg_valid = 1'b0; bus.msg_status = '0; bus.msg_data1 = '0; bus.msg_data2 = '0;
    bus.rt_valid = 1'b0; bus.rt_byte = '0; bus.running_status_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset txd", bus.midi_txd, 1'b1);
    chk("reset msg_ready", bus.msg_ready, 1'b1);
    chk("reset rt_ready", bus.rt_ready, 1'b1);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset msg_err", bus.msg_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      start_msg(vecs[v].st, vecs[v].d1, vecs[v].d2, vecs[v].en, 1'b0, 8'h00, acc);
      wait_done($sformatf("vec%0d", v), rdy);
      check_frames($sformatf("vec%0d", v), vecs[v].n, vecs[v].ex, acc);
      chk($sformatf("vec%0d ready_rise", v), rdy, acc + 1 + (vecs[v].n - 1) * FRAME);
    end

    // rt byte arrives during the 2nd frame and lands between 3C and 64
    start_msg(8'h90, 8'h3C, 8'h64, 1'b1, 1'b0, 8'h00, acc);
    repeat (FRAME + 3 * DIV) @(negedge clk);
    bus.rt_valid = 1'b1;
    bus.rt_byte = 8'hF8;
    @(posedge clk); #1;
    bus.rt_valid = 1'b0;
    @(negedge clk);
    chk("rt pending rt_ready", bus.rt_ready, 1'b0);
    wait_done("rt_mid", rdy);
    check_frames("rt_mid", 4, 32'h64F83C90, acc);

    start_msg(8'h90, 8'h3E, 8'h40, 1'b1, 1'b0, 8'h00, acc);
    wait_done("rs_after_rt", rdy);
    check_frames("rs_after_rt", 2, 32'h0000403E, acc);

    // Simultaneous message and rt request in IDLE: rt goes first
    start_msg(8'h93, 8'h01, 8'h02, 1'b1, 1'b1, 8'hFA, acc);
    wait_done("rt_simul", rdy);
    check_frames("rt_simul", 4, 32'h020193FA, acc);

    // Invalid status byte: accepted, dropped, one-cycle error pulse
    start_msg(8'h3C, 8'h11, 8'h22, 1'b1, 1'b0, 8'h00, acc);
    @(negedge clk);
    chk("invalid msg_err", bus.msg_err, 1'b1);
    chk("invalid msg_ready", bus.msg_ready, 1'b1);
    chk("invalid busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("invalid msg_err_clear", bus.msg_err, 1'b0);
    repeat (2 * FRAME) @(negedge clk);
    chk("invalid no_frames", q_byte.size(), 0);

    // Reset mid-bit aborts the frame; next message frames cleanly
    start_msg(8'h80, 8'h3C, 8'h64, 1'b1, 1'b0, 8'h00, acc);
    repeat (3 * DIV + DIV / 2) @(negedge clk);
    chk("pre_reset busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset txd", bus.midi_txd, 1'b1);
    chk("midreset busy", bus.busy, 1'b0);
    chk("midreset msg_ready", bus.msg_ready, 1'b1);
    rst_n = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    start_msg(8'h90, 8'h11, 8'h22, 1'b1, 1'b0, 8'h00, acc);
    wait_done("post_reset", rdy);
    check_frames("post_reset", 3, 32'h00221190, acc);
    chk("post_reset ready_rise", rdy, acc + 1 + 2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
